fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the fetch program counter (Pc_F), drives it to the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Computes the next PC from decode-stage redirect information (branch, j/jal, jr) with architectural delay-slot semantics. Also handles stall and flush requests from the hazard unit and flags illegal fetch addresses.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, Pc_F value after reset
- IM_LO, 32'h0000_3000, lowest legal fetch address
- IM_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Stall_F  in  1  hazard unit: hold PC and IF/ID
- Flush_D  in  1  hazard unit: load a bubble into IF/ID
- Npc_Sel  in  2  from D-stage control: 00 seq, 01 branch, 10 j/jal, 11 jr
- Branch_Taken  in  1  D-stage comparator result, used only when Npc_Sel=01
- Jr_Target  in  32  forwarded rs value for jr/jalr
- Instruction  in  32  word returned by instruction memory for Pc_F
- Pc_F  out  32  current fetch address to instruction memory
- Instr_D  out  32  IF/ID instruction
- Pc_D  out  32  IF/ID PC
- Pc8_D  out  32  IF/ID PC+8 (link value)
- Valid_D  out  1  IF/ID holds a real fetch (not a bubble)
- AdEL_D  out  1  IF/ID instruction came from an illegal address
- Fetch_Count  out  32  number of instructions accepted into IF/ID

## Operation
- Fetch address check (combinational on Pc_F): illegal if Pc_F[1:0]!=0, Pc_F<IM_LO or Pc_F>IM_HI. An illegal fetch captures Instr=32'h0 with AdEL_D=1, never the memory word.
- Next-PC select, evaluated from IF/ID contents (Valid_D must be 1, otherwise seq):
  - seq: Pc_F+4
  - branch: if Branch_Taken, Pc_D+4+(sext(Instr_D[15:0])<<2); else Pc_F+4
  - j/jal: {Pc_D[31:28], Instr_D[25:0], 2'b00}
  - jr: Jr_Target (no alignment masking; a misaligned target is caught by the address check)
- Delay slot: the word at Pc_D+4 is already in F when the branch sits in D. It is captured normally; there is no flush on redirect.
- All adds are 32-bit modulo 2^32 (wraps silently). Negative branch offsets are supported.
- Per edge, in priority order:
  - reset
  - Stall_F: PC holds. IF/ID holds, unless Flush_D is set, in which case IF/ID becomes a bubble.
  - else PC <= next-PC; IF/ID <= bubble if Flush_D, else the fetched word.
- Bubble: Instr_D=0, Pc_D=0, Pc8_D=0, Valid_D=0, AdEL_D=0.
- Normal capture: Instr_D, Pc_D=Pc_F, Pc8_D=Pc_F+8, Valid_D=1, AdEL_D=illegal flag.
- Fetch_Count increments by 1 on every normal capture (not on stall or bubble) and wraps at 2^32.

## Timing
- Reset values: Pc_F=PC_RESET; Instr_D, Pc_D, Pc8_D, Fetch_Count=0; Valid_D=0, AdEL_D=0. Reset acts asynchronously; release is mid-cycle safe.
- Pc_F is registered; Instruction must return combinationally in the same cycle.
- IF/ID latency: 1 cycle from Pc_F to Instr_D.
- Redirect latency: the target appears on Pc_F in the cycle after the branch occupies D with the delay slot on Pc_F.
- Stall during redirect: the redirect is held off. The branch stays in D and is re-evaluated in the first unstalled cycle, so the target is applied exactly once.
- Stall_F and Flush_D together: PC frozen, IF/ID bubbled, Fetch_Count unchanged.
- A redirect request while Valid_D=0 is ignored (sequential fetch).

## Test plan
- Reset then 4 free-running cycles, IM returns 0x11111111.. per word -> Pc_F 0x3000, 0x3004, 0x3008, 0x300C; Pc_D lags by one cycle; Pc8_D=Pc_D+8; Fetch_Count=3 after cycle 4.
- beq at 0x3010 with imm 0xFFFC and Branch_Taken=1 -> delay slot 0x3014 captured; next Pc_F=0x3004; with Branch_Taken=0 -> next Pc_F=0x3018.
- j with Instr_D=0x08000C10 at Pc_D=0x3000 -> next Pc_F=0x00003040; jr with Jr_Target=0x3002 -> next cycle Instr_D=0, AdEL_D=1, Valid_D=1.
- Stall_F high 2 cycles while a taken branch is in D -> Pc_F, Instr_D and Fetch_Count frozen; the target is loaded on the first unstalled edge only.
- Stall_F=1 and Flush_D=1 in the same cycle -> Pc_F unchanged, Valid_D=0, Instr_D=0.
- Assert reset mid-run at Pc_F=0x3024 -> outputs return to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns Pc_F, computes the next PC from decode-stage
// redirects (delay-slot semantics), and loads the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall_F,
    input  logic        Flush_D,
    input  logic [1:0]  Npc_Sel,
    input  logic        Branch_Taken,
    input  logic [31:0] Jr_Target,
    input  logic [31:0] Instruction,
    output logic [31:0] Pc_F,
    output logic [31:0] Instr_D,
    output logic [31:0] Pc_D,
    output logic [31:0] Pc8_D,
    output logic        Valid_D,
    output logic        AdEL_D,
    output logic [31:0] Fetch_Count
);

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    logic [31:0] pc_f_q,        pc_f_d;
    logic [31:0] instr_d_q,     instr_d_d;
    logic [31:0] pc_d_q,        pc_d_d;
    logic [31:0] pc8_d_q,       pc8_d_d;
    logic        valid_d_q,     valid_d_d;
    logic        adel_d_q,      adel_d_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        fetch_illegal;
    logic [31:0] fetch_word;
    logic [31:0] seq_pc;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    always_comb begin
        fetch_illegal = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IM_LO) || (pc_f_q > IM_HI);
        fetch_word    = fetch_illegal ? 32'h0000_0000 : Instruction;
    end

    // Redirect targets are taken from IF/ID, i.e. the branch/jump sitting in decode.
    always_comb begin
        seq_pc        = pc_f_q + 32'd4;
        branch_offset = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
        branch_target = pc_d_q + 32'd4 + branch_offset;
        jump_target   = {pc_d_q[31:28], instr_d_q[25:0], 2'b00};
        next_pc       = seq_pc;
        if (valid_d_q) begin
            case (Npc_Sel)
                NPC_SEQ:    next_pc = seq_pc;
                NPC_BRANCH: next_pc = Branch_Taken ? branch_target : seq_pc;
                NPC_JUMP:   next_pc = jump_target;
                NPC_JR:     next_pc = Jr_Target;
                default:    next_pc = seq_pc;
            endcase
        end
    end

    always_comb begin
        pc_f_d        = pc_f_q;
        instr_d_d     = instr_d_q;
        pc_d_d        = pc_d_q;
        pc8_d_d       = pc8_d_q;
        valid_d_d     = valid_d_q;
        adel_d_d      = adel_d_q;
        fetch_count_d = fetch_count_q;

        if (!Stall_F) begin
            pc_f_d = next_pc;
        end

        // A flush wins over both a stall and a normal capture.
        if (Flush_D) begin
            instr_d_d = 32'h0000_0000;
            pc_d_d    = 32'h0000_0000;
            pc8_d_d   = 32'h0000_0000;
            valid_d_d = 1'b0;
            adel_d_d  = 1'b0;
        end else if (!Stall_F) begin
            instr_d_d     = fetch_word;
            pc_d_d        = pc_f_q;
            pc8_d_d       = pc_f_q + 32'd8;
            valid_d_d     = 1'b1;
            adel_d_d      = fetch_illegal;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q        <= PC_RESET;
            instr_d_q     <= 32'h0000_0000;
            pc_d_q        <= 32'h0000_0000;
            pc8_d_q       <= 32'h0000_0000;
            valid_d_q     <= 1'b0;
            adel_d_q      <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_f_q        <= pc_f_d;
            instr_d_q     <= instr_d_d;
            pc_d_q        <= pc_d_d;
            pc8_d_q       <= pc8_d_d;
            valid_d_q     <= valid_d_d;
            adel_d_q      <= adel_d_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Pc_F        = pc_f_q;
    assign Instr_D     = instr_d_q;
    assign Pc_D        = pc_d_q;
    assign Pc8_D       = pc8_d_q;
    assign Valid_D     = valid_d_q;
    assign AdEL_D      = adel_d_q;
    assign Fetch_Count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pipeline scenarios plus randomized traffic, all
// checked every cycle against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6FFC;
    localparam logic [31:0] BEQ_M4   = 32'h1000_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        branch_taken = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] pc_f, instr_d, pc_d, pc8_d, fetch_count;
    logic        valid_d, adel_d;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(.PC_RESET(PC_RESET), .IM_LO(IM_LO), .IM_HI(IM_HI)) dut (
        .clk(clk), .reset(reset), .Stall_F(stall_f), .Flush_D(flush_d),
        .Npc_Sel(npc_sel), .Branch_Taken(branch_taken), .Jr_Target(jr_target),
        .Instruction(instruction), .Pc_F(pc_f), .Instr_D(instr_d), .Pc_D(pc_d),
        .Pc8_D(pc8_d), .Valid_D(valid_d), .AdEL_D(adel_d), .Fetch_Count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Default memory contents: word k (from 0x3000) holds (k+1)*0x11111111.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (((a - 32'h3000) >> 2) + 32'd1) * 32'h1111_1111;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc = PC_RESET;
    logic [31:0] m_instr = 32'h0, m_pcd = 32'h0, m_pc8 = 32'h0, m_count = 32'h0;
    logic        m_valid = 1'b0, m_adel = 1'b0;

    function automatic logic model_illegal(input logic [31:0] a);
        return (a % 4 != 0) || (a < IM_LO) || (a > IM_HI);
    endfunction

    function automatic logic [31:0] model_next_pc();
        logic [31:0] np;
        int off;
        np = m_pc + 32'd4;
        if (m_valid) begin
            case (npc_sel)
                2'b01: if (branch_taken) begin
                    off = $signed(m_instr[15:0]);
                    np  = m_pcd + 32'd4 + 32'(off * 4);
                end
                2'b10: np = (m_pcd & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
                2'b11: np = jr_target;
                default: ;
            endcase
        end
        return np;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= PC_RESET; m_instr <= 0; m_pcd <= 0; m_pc8 <= 0;
            m_valid <= 0; m_adel <= 0; m_count <= 0;
        end else begin
            if (!stall_f) m_pc <= model_next_pc();
            if (flush_d) begin
                m_instr <= 0; m_pcd <= 0; m_pc8 <= 0; m_valid <= 0; m_adel <= 0;
            end else if (!stall_f) begin
                m_instr <= model_illegal(m_pc) ? 32'h0 : instruction;
                m_pcd   <= m_pc;
                m_pc8   <= m_pc + 32'd8;
                m_valid <= 1'b1;
                m_adel  <= model_illegal(m_pc);
                m_count <= m_count + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        check("Pc_F", pc_f, m_pc);
        check("Instr_D", instr_d, m_instr);
        check("Pc_D", pc_d, m_pcd);
        check("Pc8_D", pc8_d, m_pc8);
        check("Valid_D", {31'h0, valid_d}, {31'h0, m_valid});
        check("AdEL_D", {31'h0, adel_d}, {31'h0, m_adel});
        check("Fetch_Count", fetch_count, m_count);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        instruction = imem(pc_f);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [31:0] r;
        #12;
        check("rst Pc_F", pc_f, 32'h3000);
        check("rst Valid_D", {31'h0, valid_d}, 32'h0);
        check("rst Fetch_Count", fetch_count, 32'h0);
        reset = 1'b0;
        instruction = imem(pc_f);

        // free-running sequential fetch
        steps(3);
        check("seq Pc_F", pc_f, 32'h300C);
        check("seq Pc_D", pc_d, 32'h3008);
        check("seq Pc8_D", pc8_d, 32'h3010);
        check("seq Instr_D", instr_d, 32'h3333_3333);
        check("seq Fetch_Count", fetch_count, 32'd3);

        // taken backward beq at 0x3010
        step();
        instruction = BEQ_M4;
        step();
        npc_sel = 2'b01; branch_taken = 1'b1;
        step();
        check("beq taken Pc_F", pc_f, 32'h3004);
        check("beq delay slot Pc_D", pc_d, 32'h3014);
        check("beq delay slot Instr_D", instr_d, 32'h6666_6666);
        npc_sel = 2'b00; branch_taken = 1'b0;

        // not-taken beq
        steps(3);
        instruction = BEQ_M4;
        step();
        npc_sel = 2'b01;
        step();
        check("beq not taken Pc_F", pc_f, 32'h3018);
        npc_sel = 2'b00;

        // j to 0x3040 from 0x3000, then jr to a misaligned target
        npc_sel = 2'b11; jr_target = 32'h3000;
        step();
        npc_sel = 2'b00;
        instruction = 32'h0800_0C10;
        step();
        npc_sel = 2'b10;
        step();
        check("j Pc_F", pc_f, 32'h3040);
        npc_sel = 2'b11; jr_target = 32'h3002;
        step();
        check("jr Pc_F", pc_f, 32'h3002);
        npc_sel = 2'b00;
        instruction = 32'hDEAD_BEEF;
        step();
        check("adel Instr_D", instr_d, 32'h0);
        check("adel AdEL_D", {31'h0, adel_d}, 32'h1);
        check("adel Valid_D", {31'h0, valid_d}, 32'h1);
        check("adel Pc8_D", pc8_d, 32'h300A);
        npc_sel = 2'b11; jr_target = 32'h3000;
        step();
        npc_sel = 2'b00;

        // stall while a taken branch sits in D
        steps(4);
        instruction = BEQ_M4;
        step();
        npc_sel = 2'b01; branch_taken = 1'b1; stall_f = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall Pc_F", pc_f, 32'h3014);
            check("stall Instr_D", instr_d, BEQ_M4);
            check("stall Fetch_Count", fetch_count, 32'd22);
        end
        stall_f = 1'b0;
        step();
        check("unstall Pc_F", pc_f, 32'h3004);
        npc_sel = 2'b00; branch_taken = 1'b0;
        step();
        check("once Pc_F", pc_f, 32'h3008);

        // stall and flush together
        stall_f = 1'b1; flush_d = 1'b1;
        step();
        check("stflush Pc_F", pc_f, 32'h3008);
        check("stflush Valid_D", {31'h0, valid_d}, 32'h0);
        check("stflush Instr_D", instr_d, 32'h0);
        check("stflush Fetch_Count", fetch_count, 32'd24);
        stall_f = 1'b0; flush_d = 1'b0;

        // asynchronous reset mid-run
        steps(7);
        check("pre-reset Pc_F", pc_f, 32'h3024);
        #2 reset = 1'b1;
        #1;
        check("async rst Pc_F", pc_f, 32'h3000);
        check("async rst Pc_D", pc_d, 32'h0);
        check("async rst Valid_D", {31'h0, valid_d}, 32'h0);
        check("async rst Fetch_Count", fetch_count, 32'h0);
        #3 reset = 1'b0;
        instruction = imem(pc_f);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            stall_f      = ($urandom_range(0, 9) < 2);
            flush_d      = ($urandom_range(0, 9) < 1);
            npc_sel      = 2'($urandom_range(0, 3));
            branch_taken = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: jr_target = $urandom;
                1: jr_target = 32'hFFFF_FFFC;
                2: jr_target = 32'h3000 + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(1, 3));
                default: jr_target = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            endcase
            r = $urandom;
            if ($urandom_range(0, 1) == 1)
                r[25:0] = 26'((32'h3000 + 32'($urandom_range(0, 4095)) * 4) >> 2);
            if ($urandom_range(0, 3) != 0) instruction = r;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
